// File: rtl/dp_pkg.sv
// Shared definitions for the pipelined datapath: ALU operation codes and
// the bit positions of the instruction fields.
package dp_pkg;

  localparam int REG_IDX_W = 5;
  localparam int INSTR_W   = 26;

  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_XOR = 4'd3,
    ALU_SLL = 4'd4,
    ALU_SRL = 4'd5,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_op_e;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU. Shifts act on operand B by shamt; the overflow flag is
// only meaningful for ADD and SUB and reads 0 for every other operation.
module dp_alu
  import dp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [SHW-1:0]  shamt,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] res,
  output logic            ovf
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Select the operation result and derive signed overflow for ADD/SUB
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_ADD: begin
        res = sum;
        ovf = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_XOR: res = a ^ b;
      ALU_SLL: res = b << shamt;
      ALU_SRL: res = b >> shamt;
      ALU_SUB: begin
        res = diff;
        ovf = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_SLT: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: res = ~(a | b);
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_datapath.sv
// Register file + ALU datapath with one registered EX/WB stage.
// Operands are read and the ALU evaluated in the accept cycle; the result
// sits in EX/WB until downstream takes it, and the architectural register
// write happens on that retire edge. A pending writeback is forwarded to
// operand reads so back-to-back dependent instructions see it.
//
// Handshake: an instruction is accepted on a rising edge where
// in_valid && in_ready; a result retires on an edge where
// out_valid && out_ready. in_ready = !out_valid || out_ready, so a stalled
// result blocks new work, and retire + accept on the same edge is allowed.
module pipelined_datapath
  import dp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IMM_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 RegDst,
  input  logic                 ALUSrc,
  input  logic                 RegWrite,
  input  logic                 MemToReg,
  input  logic [3:0]           op,
  input  logic [INSTR_W-1:0]   instruction,
  input  logic [XLEN-1:0]      WdataIn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      result,
  output logic                 Z,
  output logic                 ovf,
  output logic [XLEN-1:0]      WdataOut,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [XLEN-1:0]      dbg_data
);

  localparam int SHW = $clog2(XLEN);
  localparam int NIDX = 1 << REG_IDX_W;
  localparam logic [REG_IDX_W:0] NREGS_LIM = NREGS[REG_IDX_W:0];

  // Instruction fields
  logic [REG_IDX_W-1:0] rs_idx, rt_idx, rd_idx, dest_in;
  logic [REG_IDX_W-1:0] shamt_fld;
  logic [XLEN-1:0]      imm_ext;

  assign rs_idx    = instruction[RS_MSB:RS_LSB];
  assign rt_idx    = instruction[RT_MSB:RT_LSB];
  assign rd_idx    = instruction[RD_MSB:RD_LSB];
  assign shamt_fld = instruction[SHAMT_MSB:SHAMT_LSB];
  assign imm_ext   = XLEN'($signed(instruction[IMM_W-1:0]));
  assign dest_in   = RegDst ? rd_idx : rt_idx;

  // Architectural state and EX/WB register
  logic [XLEN-1:0]      regs_q [1:NREGS-1];
  logic [XLEN-1:0]      regs_d [1:NREGS-1];
  logic [XLEN-1:0]      rf_view [NIDX];

  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic                 z_q, z_d;
  logic                 ovf_q, ovf_d;
  logic [XLEN-1:0]      wdata_out_q, wdata_out_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic [REG_IDX_W-1:0] dest_q, dest_d;
  logic                 wb_we_q, wb_we_d;

  logic                 accept, retire, wb_pending, dest_live;
  logic [XLEN-1:0]      rs_val, rt_val, alu_b, alu_res;
  logic                 alu_ovf;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid_q && out_ready;

  // Index 0 and indices beyond NREGS hold nothing and are never written.
  assign dest_live  = (dest_q != '0) && ({1'b0, dest_q} < NREGS_LIM);
  assign wb_pending = out_valid_q && wb_we_q && dest_live;

  // Flattened view of the register file: unbacked indices read as zero.
  for (genvar gi = 0; gi < NIDX; gi++) begin : g_view
    if (gi == 0 || gi >= NREGS) begin : g_zero
      assign rf_view[gi] = '0;
    end else begin : g_reg
      assign rf_view[gi] = regs_q[gi];
    end
  end

  assign dbg_data = rf_view[dbg_addr];

  // Operand read with forwarding of the result waiting in EX/WB
  always_comb begin
    rs_val = rf_view[rs_idx];
    rt_val = rf_view[rt_idx];
    if (wb_pending && (dest_q == rs_idx)) rs_val = wb_data_q;
    if (wb_pending && (dest_q == rt_idx)) rt_val = wb_data_q;
  end

  assign alu_b = ALUSrc ? imm_ext : rt_val;

  dp_alu #(.XLEN(XLEN), .SHW(SHW)) u_alu (
    .a     (rs_val),
    .b     (alu_b),
    .shamt (SHW'(shamt_fld)),
    .op    (op),
    .res   (alu_res),
    .ovf   (alu_ovf)
  );

  // EX/WB next state: load on accept, clear valid on retire, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    z_d         = z_q;
    ovf_d       = ovf_q;
    wdata_out_d = wdata_out_q;
    wb_data_d   = wb_data_q;
    dest_d      = dest_q;
    wb_we_d     = wb_we_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      z_d         = (alu_res == '0);
      ovf_d       = alu_ovf;
      wdata_out_d = rt_val;
      wb_data_d   = MemToReg ? WdataIn : alu_res;
      dest_d      = dest_in;
      wb_we_d     = RegWrite;
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
  end

  // Register file next state: commit the EX/WB value on its retire edge
  always_comb begin
    regs_d = regs_q;
    if (retire && wb_pending) begin
      for (int i = 1; i < NREGS; i++) begin
        if (dest_q == REG_IDX_W'(i)) regs_d[i] = wb_data_q;
      end
    end
  end

  // State registers; reset clears the file and drops any pending result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      z_q         <= 1'b0;
      ovf_q       <= 1'b0;
      wdata_out_q <= '0;
      wb_data_q   <= '0;
      dest_q      <= '0;
      wb_we_q     <= 1'b0;
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      z_q         <= z_d;
      ovf_q       <= ovf_d;
      wdata_out_q <= wdata_out_d;
      wb_data_q   <= wb_data_d;
      dest_q      <= dest_d;
      wb_we_q     <= wb_we_d;
      regs_q      <= regs_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign Z         = z_q;
  assign ovf       = ovf_q;
  assign WdataOut  = wdata_out_q;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench for pipelined_datapath (XLEN=32, NREGS=8, IMM_W=16).
// A sequential reference model computes each instruction's outcome when it
// is accepted; the expected {result, WdataOut, Z, ovf} is queued and compared
// when the DUT retires it. Tasks add their own direct checks on handshake,
// hold-under-backpressure and architectural register contents.
module tb_pipelined_datapath;
  import dp_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 8;
  localparam int IMM_W = 16;
  localparam int EW    = 2 * XLEN + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic            RegDst, ALUSrc, RegWrite, MemToReg;
  logic [3:0]      op;
  logic [25:0]     instruction;
  logic [XLEN-1:0] WdataIn;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] result, WdataOut, dbg_data;
  logic            Z, ovf;
  logic [4:0]      dbg_addr;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [EW-1:0]   exp_q[$];
  logic [XLEN-1:0] model_rf [32];

  pipelined_datapath #(.XLEN(XLEN), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .RegDst      (RegDst),
    .ALUSrc      (ALUSrc),
    .RegWrite    (RegWrite),
    .MemToReg    (MemToReg),
    .op          (op),
    .instruction (instruction),
    .WdataIn     (WdataIn),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .Z           (Z),
    .ovf         (ovf),
    .WdataOut    (WdataOut),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= NREGS) return '0;
    return model_rf[idx];
  endfunction

  function automatic logic [EW-1:0] model_exec(
    input logic [3:0] f_op, input logic [4:0] rs, input logic [4:0] rt,
    input logic [15:0] low, input logic regdst, input logic alusrc,
    input logic regwrite, input logic memtoreg, input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] a, b, st, res;
    logic [4:0] rd, sh, dest;
    logic ov;
    a  = model_read(rs);
    st = model_read(rt);
    b  = alusrc ? {{16{low[15]}}, low} : st;
    rd = low[15:11];
    sh = low[10:6];
    ov = 1'b0;
    case (f_op)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  begin res = a + b; ov = (a[31] == b[31]) && (res[31] != a[31]); end
      4'd3:  res = a ^ b;
      4'd4:  res = b << sh;
      4'd5:  res = b >> sh;
      4'd6:  begin res = a - b; ov = (a[31] != b[31]) && (res[31] != a[31]); end
      4'd7:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: res = ~(a | b);
      default: res = '0;
    endcase
    dest = regdst ? rd : rt;
    if (regwrite && dest != 5'd0 && int'(dest) < NREGS)
      model_rf[dest] = memtoreg ? wdata : res;
    return {res, st, (res == '0), ov};
  endfunction

  function automatic logic [15:0] rfield(input logic [4:0] rd, input logic [4:0] sh);
    return {rd, sh, 6'd0};
  endfunction

  // ---------------- scoreboard ----------------
  // Compare each retiring result against the oldest expected entry.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: result=%h retired with no expected entry", result);
      end else begin
        e = exp_q.pop_front();
        if ({result, WdataOut, Z, ovf} !== e) begin
          tests_failed++;
          $display("FAIL sb_result: got result=%h wdata=%h Z=%b ovf=%b, expected result=%h wdata=%h Z=%b ovf=%b",
                   result, WdataOut, Z, ovf, e[EW-1 -: XLEN], e[XLEN+1 +: XLEN], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] f_op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [15:0] low, input logic regdst, input logic alusrc,
                       input logic regwrite, input logic memtoreg, input logic [XLEN-1:0] wdata);
    bit accepted = 0;
    in_valid    = 1'b1;
    op          = f_op;
    instruction = {rs, rt, low};
    RegDst      = regdst;
    ALUSrc      = alusrc;
    RegWrite    = regwrite;
    MemToReg    = memtoreg;
    WdataIn     = wdata;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        exp_q.push_back(model_exec(f_op, rs, rt, low, regdst, alusrc, regwrite, memtoreg, wdata));
        accepted = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      tests_run++;
      tests_failed++;
      $display("FAIL issue_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (out_valid === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_timeout: out_valid=%b, required 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    RegDst = 0; ALUSrc = 0; RegWrite = 0; MemToReg = 0;
    op = 4'd0; instruction = '0; WdataIn = '0; dbg_addr = 5'd1;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, in_ready, Z, ovf} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset_flags: out_valid/in_ready/Z/ovf=%b, required 0100", {out_valid, in_ready, Z, ovf});
    end
    tests_run++;
    if (result !== '0 || WdataOut !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: result=%h WdataOut=%h, required 0", result, WdataOut);
    end
    tests_run++;
    if (dbg_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_reg: r1=%h, required 0", dbg_data);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_bypass();
    logic [XLEN-1:0] want [1:4];
    issue(ALU_AND, 5'd0, 5'd0, rfield(5'd1, 5'd0), 1, 0, 1, 1, 32'd40);
    issue(ALU_AND, 5'd0, 5'd0, rfield(5'd2, 5'd0), 1, 0, 1, 1, 32'd20);
    issue(ALU_ADD, 5'd1, 5'd2, rfield(5'd3, 5'd0), 1, 0, 1, 0, 32'd0);
    issue(ALU_SUB, 5'd3, 5'd2, rfield(5'd4, 5'd0), 1, 0, 1, 0, 32'd0);
    issue(ALU_SUB, 5'd1, 5'd1, rfield(5'd5, 5'd0), 1, 0, 1, 0, 32'd0);
    drain();
    want[1] = 32'd40; want[2] = 32'd20; want[3] = 32'd60; want[4] = 32'd40;
    for (int i = 1; i <= 4; i++) begin
      dbg_addr = 5'(i);
      #1;
      tests_run++;
      if (dbg_data !== want[i]) begin
        tests_failed++;
        $display("FAIL load_bypass_r%0d: got %0d, required %0d", i, dbg_data, want[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    dbg_addr  = 5'd6;
    issue(ALU_ADD, 5'd3, 5'd1, rfield(5'd6, 5'd0), 1, 0, 1, 0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd100 || dbg_data !== '0) begin
        tests_failed++;
        $display("FAIL backpressure_hold: in_ready=%b out_valid=%b result=%0d r6=%0d, required 0 1 100 0",
                 in_ready, out_valid, result, dbg_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (dbg_data !== '0) begin
      tests_failed++;
      $display("FAIL backpressure_early_write: r6=%0d before retire edge, required 0", dbg_data);
    end
    @(posedge clk); #1;
    tests_run++;
    if (dbg_data !== 32'd100 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_retire: r6=%0d out_valid=%b, required 100 0", dbg_data, out_valid);
    end
  endtask

  task automatic test_imm_ovf();
    issue(ALU_ADD, 5'd1, 5'd7, 16'hFFFF, 0, 1, 1, 0, 32'd0);
    issue(ALU_AND, 5'd0, 5'd4, 16'h0000, 0, 0, 1, 1, 32'h7FFF_FFFF);
    issue(ALU_ADD, 5'd4, 5'd5, 16'h0001, 0, 1, 1, 0, 32'd0);
    issue(ALU_AND, 5'd0, 5'd6, 16'h0000, 0, 0, 1, 1, 32'hFFFF_FFFF);
    issue(ALU_SLT, 5'd6, 5'd2, 16'h0001, 0, 1, 1, 0, 32'd0);
    issue(ALU_SUB, 5'd5, 5'd3, 16'h0001, 0, 1, 0, 0, 32'd0);
    drain();
    dbg_addr = 5'd7; #1;
    tests_run++;
    if (dbg_data !== 32'd39) begin
      tests_failed++;
      $display("FAIL imm_sext: r7=%0d, required 39", dbg_data);
    end
    dbg_addr = 5'd5; #1;
    tests_run++;
    if (dbg_data !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL imm_ovf_add: r5=%h, required 80000000", dbg_data);
    end
    dbg_addr = 5'd2; #1;
    tests_run++;
    if (dbg_data !== 32'd1) begin
      tests_failed++;
      $display("FAIL imm_slt: r2=%0d, required 1", dbg_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r0_range();
    issue(ALU_AND, 5'd0, 5'd0, rfield(5'd0, 5'd0), 1, 0, 1, 1, 32'h0000_DEAD);
    issue(ALU_OR,  5'd0, 5'd0, rfield(5'd3, 5'd0), 1, 0, 1, 0, 32'd0);
    issue(ALU_AND, 5'd0, 5'd0, rfield(5'd9, 5'd0), 1, 0, 1, 1, 32'h0000_0055);
    issue(ALU_ADD, 5'd9, 5'd1, rfield(5'd4, 5'd0), 1, 0, 1, 0, 32'd0);
    drain();
    dbg_addr = 5'd0; #1;
    tests_run++;
    if (dbg_data !== '0) begin
      tests_failed++;
      $display("FAIL r0_write: r0=%h, required 0", dbg_data);
    end
    dbg_addr = 5'd9; #1;
    tests_run++;
    if (dbg_data !== '0) begin
      tests_failed++;
      $display("FAIL range_read: idx9=%h, required 0", dbg_data);
    end
    dbg_addr = 5'd1; #1;
    tests_run++;
    if (dbg_data !== model_read(5'd1)) begin
      tests_failed++;
      $display("FAIL range_alias: r1=%h, required %h", dbg_data, model_read(5'd1));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        out_ready = 1'b0;
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      issue(4'($urandom_range(0, 15)), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
            16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), $urandom);
    end
    drain();
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = 5'(i);
      #1;
      tests_run++;
      if (dbg_data !== model_read(5'(i))) begin
        tests_failed++;
        $display("FAIL random_rf_r%0d: got %h, required %h", i, dbg_data, model_read(5'(i)));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    issue(ALU_AND, 5'd0, 5'd0, rfield(5'd3, 5'd0), 1, 0, 1, 1, 32'h0000_ABCD);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || result !== '0 || WdataOut !== '0 || Z !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_stage: out_valid=%b result=%h WdataOut=%h Z=%b ovf=%b, required all 0",
               out_valid, result, WdataOut, Z, ovf);
    end
    dbg_addr = 5'd1; #1;
    tests_run++;
    if (dbg_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_regs: r1=%h, required 0", dbg_data);
    end
    exp_q.delete();
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    dbg_addr = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (dbg_data !== '0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_lost: r3=%h out_valid=%b, required 0 0", dbg_data, out_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load_bypass();
    test_backpressure();
    test_imm_ovf();
    test_r0_range();
    test_random();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: %0d expected results never retired, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
